// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the program sequencer: sequencer state
//               encoding, the HALT instruction word, opcode constants and the
//               bit positions of the instruction fields.
//               Instruction format: mode[7] opcode[6:4] regA[3:2] regB[1:0]
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Sequencer state encoding, also driven directly onto the state port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_WAIT   = 2'b10,
    ST_HALTED = 2'b11
  } seq_state_t;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;
  localparam int MEM_DEPTH = 16;

  // An all-zero word stops the sequencer instead of being issued.
  localparam logic [INSTR_W-1:0] HALT_INSTR = 8'h00;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_INC = 3'b011;

  localparam int MODE_BIT = 7;
  localparam int OPC_MSB  = 6;
  localparam int OPC_LSB  = 4;
  localparam int REGA_MSB = 3;
  localparam int REGA_LSB = 2;
  localparam int REGB_MSB = 1;
  localparam int REGB_LSB = 0;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr == HALT_INSTR;
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem
// Description : 16 x 8 program memory. Asynchronous active-low reset clears
//               every word to zero, writes are synchronous, the read port is
//               purely combinational.
// Ports       : clock_pulse - clock, rising edge
//               resetn      - asynchronous active-low reset
//               i_we        - write enable
//               i_waddr     - write address
//               i_wdata     - write data
//               i_raddr     - read address
//               o_rdata     - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = PC_W,
  parameter int DW    = INSTR_W
) (
  input  logic          clock_pulse,
  input  logic          resetn,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // One register per word so that reset can clear the whole array at once.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clock_pulse or negedge resetn) begin
      if (!resetn) begin
        r_mem[gi] <= '0;
      end else if (i_we && (i_waddr == AW'(gi))) begin
        r_mem[gi] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : prog_mem
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer
// Description : Fetches instructions from a 16-word program memory and offers
//               them to a datapath with a valid/ready handshake, then waits
//               for writeback before moving on. Supports continuous run,
//               single step, a sticky halt request and an in-memory HALT word.
// Ports       : clock_pulse - clock, rising edge
//               resetn      - asynchronous active-low reset
//               load_en/load_addr/load_instr - program load (IDLE only)
//               run, step, halt_req, clear   - control
//               issue_valid/issue_instr/issue_ready - issue handshake
//               wb_done     - datapath writeback complete
//               pc, state, retired           - status
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer
  import cpu_pkg::*;
(
  input  logic               clock_pulse,
  input  logic               resetn,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic               clear,
  output logic               issue_valid,
  output logic [INSTR_W-1:0] issue_instr,
  input  logic               issue_ready,
  input  logic               wb_done,
  output logic [PC_W-1:0]    pc,
  output logic [1:0]         state,
  output logic [7:0]         retired
);

  seq_state_t         r_state;
  seq_state_t         w_next_state;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_next_pc;
  logic [7:0]         r_retired;
  logic               r_halt_flag;
  logic               r_step_mode;
  logic               w_mem_we;
  logic [INSTR_W-1:0] w_mem_rdata;
  logic               w_is_halt;
  logic               w_retire;
  logic               w_enter_idle;
  logic               w_halt_pending;

  // Program can only change while nothing is executing.
  assign w_mem_we = load_en && (r_state == ST_IDLE);

  prog_mem u_prog_mem (
    .clock_pulse (clock_pulse),
    .resetn      (resetn),
    .i_we        (w_mem_we),
    .i_waddr     (load_addr),
    .i_wdata     (load_instr),
    .i_raddr     (r_pc),
    .o_rdata     (w_mem_rdata)
  );

  assign w_is_halt = is_halt(w_mem_rdata);
  assign w_retire  = (r_state == ST_WAIT) && wb_done;

  // A halt request arriving in the same cycle as wb_done still stops the
  // sequencer after this instruction rather than one instruction later.
  assign w_halt_pending = r_halt_flag || halt_req;

  // Moore issue outputs; pc and memory are frozen in ISSUE so they hold
  // stable while the datapath back-pressures.
  always_comb begin
    issue_valid = 1'b0;
    issue_instr = '0;
    if ((r_state == ST_ISSUE) && !w_is_halt) begin
      issue_valid = 1'b1;
      issue_instr = w_mem_rdata;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    case (r_state)
      ST_IDLE: begin
        if (clear) begin
          w_next_pc = '0;
        end else if (run || step) begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_is_halt) begin
          w_next_state = ST_HALTED;
        end else if (issue_ready) begin
          w_next_state = ST_WAIT;
          w_next_pc    = r_pc + 1'b1;
        end
      end
      ST_WAIT: begin
        if (wb_done) begin
          w_next_state = (r_step_mode || w_halt_pending) ? ST_IDLE : ST_ISSUE;
        end
      end
      ST_HALTED: begin
        if (clear) begin
          w_next_state = ST_IDLE;
          w_next_pc    = '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_enter_idle = (w_next_state == ST_IDLE) && (r_state != ST_IDLE);

  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_retired   <= '0;
      r_halt_flag <= 1'b0;
      r_step_mode <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
      if (w_enter_idle) begin
        r_halt_flag <= 1'b0;
      end else if (halt_req) begin
        r_halt_flag <= 1'b1;
      end
      // run wins over step when both are requested together.
      if ((r_state == ST_IDLE) && !clear) begin
        if (run) begin
          r_step_mode <= 1'b0;
        end else if (step) begin
          r_step_mode <= 1'b1;
        end
      end
    end
  end

  assign pc      = r_pc;
  assign state   = r_state;
  assign retired = r_retired;

endmodule : program_sequencer
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_sequencer
// Description : Directed self-checking bench for program_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

  logic       clock_pulse;
  logic       resetn;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_instr;
  logic       run;
  logic       step;
  logic       halt_req;
  logic       clear;
  logic       issue_valid;
  logic [7:0] issue_instr;
  logic       issue_ready;
  logic       wb_done;
  logic [3:0] pc;
  logic [1:0] state;
  logic [7:0] retired;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ISSUE  = 2'b01;
  localparam logic [1:0] S_WAIT   = 2'b10;
  localparam logic [1:0] S_HALTED = 2'b11;

  int passed = 0;
  int total  = 0;

  program_sequencer dut (
    .clock_pulse (clock_pulse),
    .resetn      (resetn),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_instr  (load_instr),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .clear       (clear),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_ready (issue_ready),
    .wb_done     (wb_done),
    .pc          (pc),
    .state       (state),
    .retired     (retired)
  );

  initial clock_pulse = 1'b0;
  always #5 clock_pulse = ~clock_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clock_pulse);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_instr = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #3 resetn = 1'b1;
    tick();
  endtask

  initial begin
    resetn = 1'b0; load_en = 1'b0; load_addr = '0; load_instr = '0;
    run = 1'b0; step = 1'b0; halt_req = 1'b0; clear = 1'b0;
    issue_ready = 1'b0; wb_done = 1'b0;
    #1;
    check("rst_state", state, S_IDLE);
    check("rst_pc", pc, 0);
    check("rst_retired", retired, 0);
    check("rst_valid", issue_valid, 0);
    check("rst_instr", issue_instr, 0);
    #13 resetn = 1'b1;
    tick();

    // ---- Scenario 1: run through 13, 31, HALT ----
    load(4'd0, 8'h13);
    load(4'd1, 8'h31);
    load(4'd2, 8'h00);
    run = 1'b1; tick(); run = 1'b0;
    check("s1_issue0_state", state, S_ISSUE);
    check("s1_issue0_valid", issue_valid, 1);
    check("s1_issue0_instr", issue_instr, 8'h13);
    issue_ready = 1'b1;
    tick();
    check("s1_wait0_state", state, S_WAIT);
    check("s1_wait0_pc", pc, 1);
    check("s1_wait0_valid", issue_valid, 0);
    wb_done = 1'b1; tick(); wb_done = 1'b0;
    check("s1_issue1_state", state, S_ISSUE);
    check("s1_issue1_instr", issue_instr, 8'h31);
    check("s1_ret1", retired, 1);
    tick();
    check("s1_wait1_pc", pc, 2);
    wb_done = 1'b1; tick(); wb_done = 1'b0;
    check("s1_issue2_state", state, S_ISSUE);
    check("s1_halt_valid", issue_valid, 0);
    tick();
    issue_ready = 1'b0;
    check("s1_halted_state", state, S_HALTED);
    check("s1_halted_pc", pc, 2);
    check("s1_halted_ret", retired, 2);

    // ---- Scenario 5: HALTED ignores run/step/load, clear exits ----
    run = 1'b1; step = 1'b1; load_en = 1'b1; load_addr = 4'd2; load_instr = 8'h31;
    tick();
    run = 1'b0; step = 1'b0; load_en = 1'b0;
    check("s5_stay_halted", state, S_HALTED);
    check("s5_pc_kept", pc, 2);
    clear = 1'b1; tick(); clear = 1'b0;
    check("s5_clear_state", state, S_IDLE);
    check("s5_clear_pc", pc, 0);

    // ---- Scenario 2: single step with back-pressure ----
    do_reset();
    load(4'd0, 8'h13);
    step = 1'b1; tick(); step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s2_hold_valid", issue_valid, 1);
      check("s2_hold_instr", issue_instr, 8'h13);
      check("s2_hold_pc", pc, 0);
      tick();
    end
    check("s2_hold_state", state, S_ISSUE);
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;
    check("s2_wait_state", state, S_WAIT);
    wb_done = 1'b1; tick(); wb_done = 1'b0;
    check("s2_idle_state", state, S_IDLE);
    check("s2_idle_pc", pc, 1);
    check("s2_retired", retired, 1);
    // wb_done outside WAIT must not count
    wb_done = 1'b1; tick(); wb_done = 1'b0;
    check("s2_wb_ignored", retired, 1);

    // ---- Scenario 3: 16 x 8'h31, halt_req in last WAIT, pc wraps ----
    do_reset();
    for (int a = 0; a < 16; a++) load(4'(a), 8'h31);
    run = 1'b1; tick(); run = 1'b0;
    issue_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("s3_issue_pc", pc, 32'(i));
      check("s3_issue_instr", issue_instr, 8'h31);
      tick();
      check("s3_wait_state", state, S_WAIT);
      if (i == 15) halt_req = 1'b1;
      wb_done = 1'b1; tick(); wb_done = 1'b0; halt_req = 1'b0;
    end
    issue_ready = 1'b0;
    check("s3_end_state", state, S_IDLE);
    check("s3_end_pc", pc, 0);
    check("s3_end_retired", retired, 16);
    // Halt flag was cleared on entering IDLE: a new run keeps going.
    run = 1'b1; tick(); run = 1'b0;
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;
    wb_done = 1'b1; tick(); wb_done = 1'b0;
    check("s3_flag_cleared", state, S_ISSUE);
    check("s3_rerun_pc", pc, 1);

    // ---- Scenario 4: run beats step; load_en ignored in ISSUE ----
    do_reset();
    load(4'd0, 8'h13);
    run = 1'b1; step = 1'b1; tick(); run = 1'b0; step = 1'b0;
    check("s4_issue_state", state, S_ISSUE);
    load_en = 1'b1; load_addr = 4'd0; load_instr = 8'hFF; tick(); load_en = 1'b0;
    check("s4_mem_unchanged", issue_instr, 8'h13);
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;
    wb_done = 1'b1; tick(); wb_done = 1'b0;
    check("s4_run_mode", state, S_ISSUE);
    check("s4_pc", pc, 1);
    tick();
    check("s4_halted", state, S_HALTED);
    clear = 1'b1; tick(); clear = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    check("s4_mem0_again", issue_instr, 8'h13);

    // ---- Scenario 6: reset asserted during WAIT ----
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;
    check("s6_pre_state", state, S_WAIT);
    wb_done = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("s6_rst_state", state, S_IDLE);
    check("s6_rst_pc", pc, 0);
    check("s6_rst_retired", retired, 0);
    check("s6_rst_valid", issue_valid, 0);
    #2 resetn = 1'b1; wb_done = 1'b0;
    tick();
    check("s6_no_retire", retired, 0);
    run = 1'b1; tick(); run = 1'b0;
    check("s6_mem_cleared", issue_valid, 0);
    tick();
    check("s6_halted", state, S_HALTED);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_program_sequencer
`default_nettype wire

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be, in order:
- clock_pulse  in  1  system clock, rising edge active
- resetn  in  1  asynchronous active-low reset
- load_en  in  1  write load_instr into program memory at load_addr
- load_addr  in  4  program memory write address
- load_instr  in  8  instruction word, format mode[7] opcode[6:4] regA[3:2] regB[1:0]
- run  in  1  start continuous execution from pc
- step  in  1  issue exactly one instruction from pc
- halt_req  in  1  request stop after the in-flight instruction
- clear  in  1  set pc to 0 and leave HALTED
- issue_valid  out  1  issue_instr is valid for the datapath
- issue_instr  out  8  instruction offered to the datapath
- issue_ready  in  1  datapath accepts issue_instr
- wb_done  in  1  datapath finished writeback of the accepted instruction
- pc  out  4  address of the next instruction
- state  out  2  IDLE=00, ISSUE=01, WAIT=10, HALTED=11
- retired  out  8  count of completed instructions

Function
REQ-003 Program memory SHALL be 16 x 8, with synchronous write and asynchronous read at pc.
REQ-004 load_en SHALL write only in IDLE; the block SHALL ignore load_en in all other states.
REQ-005 In IDLE, asserting run SHALL move to ISSUE in run mode on the next edge.
REQ-006 In IDLE, asserting step SHALL move to ISSUE in step mode on the next edge.
REQ-007 If run and step are asserted together, run SHALL take priority.
REQ-008 In IDLE, clear SHALL set pc to 0; clear SHALL take priority over run and step.
REQ-009 ISSUE outputs (Moore):
- issue_valid=1 and issue_instr=mem[pc], unless mem[pc]==HALT_INSTR (8'h00)
- for HALT_INSTR, issue_valid=0 and the next state SHALL be HALTED, with pc unchanged
REQ-010 While in ISSUE with issue_valid=1 and issue_ready=0, issue_valid and issue_instr SHALL hold stable.
REQ-011 When issue_valid && issue_ready in ISSUE, the next state SHALL be WAIT and pc SHALL become pc+1 mod 16 (15 wraps to 0).
REQ-012 In WAIT, issue_valid SHALL be 0. On wb_done, retired SHALL increment (mod 256), and the next state SHALL be:
- IDLE if in step mode or if the halt flag is set
- otherwise ISSUE
REQ-013 The block SHALL ignore wb_done outside WAIT.
REQ-014 halt_req SHALL set a sticky halt flag in any state. The flag SHALL be cleared on entry to IDLE.
REQ-015 If halt_req is seen in ISSUE before acceptance, the block SHALL complete the handshake and the WAIT phase, then go to IDLE.
REQ-016 HALTED SHALL be exited only by clear (to IDLE, pc=0) or by reset; run, step and load_en SHALL be ignored in HALTED.
REQ-017 Latency:
- run or step at edge N gives issue_valid=1 after edge N
- acceptance at edge M gives pc+1 and WAIT after edge M
- wb_done at edge K gives the next issue_valid after edge K in run mode

Reset
REQ-018 When resetn=0, the block SHALL immediately force:
- state=IDLE, pc=0, retired=0
- halt flag=0, mode=run
- issue_valid=0, issue_instr=0
- all program memory words=8'h00
REQ-019 Reset asserted mid-handshake or in WAIT SHALL abandon the in-flight instruction, with no retired increment.

Structure
REQ-020 A shared package cpu_pkg SHALL hold:
- the state encoding constants
- HALT_INSTR
- opcode constants ADD=3'b001 and INC=3'b011
- the instruction field positions
REQ-021 Program memory SHALL be one sub-module, prog_mem (16x8, async reset, sync write, async read); the FSM, pc and counter SHALL stay in program_sequencer.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Load mem[0]=8'h13, mem[1]=8'h31, mem[2]=8'h00; run; ready=1; wb_done one cycle after each acceptance -> instrs 13,31 issued, HALTED with pc=2, retired=2.
- Step with mem[0]=8'h13, ready held 0 for 3 cycles -> issue_instr=13 stable 3 cycles; after acceptance and wb_done -> IDLE, pc=1, retired=1.
- Fill all 16 words with 8'h31, run, assert halt_req while pc=15 in WAIT -> pc wraps to 0, state IDLE, retired=16.
- In IDLE, assert run and step together -> run mode; load_en during ISSUE with addr 0, data 8'hFF -> mem[0] unchanged.
- In HALTED, pulse run and step -> stays HALTED; pulse clear -> IDLE, pc=0.
- Drop resetn during WAIT -> immediate IDLE, pc=0, retired=0, issue_valid=0, mem cleared.
